game_sched: RTL and testbench
=============================

// Module: game_sched
// PURPOSE
//   Scheduler for one HEROE round: paces the game tick, spawns and advances the obstacle
//   across the 4-digit 7-seg, and tracks the hero posture from keypad presses.
//   Decides collision or clear and reports the result on W_or_L to fsm.
//   Sits between keypad/fsm and display. Drives heroe/obstacle variants and position.
// PARAMETERS
//   TICK_DIV    12_500_000  clk cycles per game tick (4 Hz at 50 MHz); >=2
//   HOLD_TICKS  2           ticks a jump/duck posture is held after a press; >=1
//   WIN_SCORE   16          obstacles cleared to win; 1..31
//   PLAY_STATE  3'd2        value of presente meaning "round in progress"
// PORTS
//   clk             in   1  system clock
//   rst_n           in   1  asynchronous active-low reset
//   presente        in   3  current fsm state
//   key             in   5  keypad code; 5'd2 = JUMP, 5'd8 = DUCK, others ignored
//   keypad_pressed  in   1  level, high while a key is held
//   W_or_L          out  2  00 playing/idle, 01 win, 10 lose (11 never driven)
//   var_h           out  2  hero posture: 00 stand, 01 jump, 10 duck
//   tipo_obs        out  4  [0]=1 high obstacle (duck clears), 0 low (jump clears); [3:1] glyph
//   obs_pos         out  2  obstacle digit, 3 = entry (leftmost lit), 0 = hero digit
//   obs_valid       out  1  obstacle on screen
//   score           out  5  obstacles cleared this round
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; LFSR = 8'hA5; tick counter 0.
//   Tick: counter runs only outside IDLE, 0..TICK_DIV-1; one-cycle tick on wrap; cleared in IDLE.
//   LFSR: 8-bit Fibonacci, taps 8,6,5,4; steps once per SPAWN.
//   FSM (one transition per clk):
//     IDLE : W_or_L=00, score=0, obs_valid=0, var_h=00; presente==PLAY_STATE -> SPAWN.
//     SPAWN: obs_pos=3, obs_valid=1, tipo_obs=lfsr[3:0] -> RUN.
//     RUN  : wait; on tick -> MOVE.
//     MOVE : obs_pos-=1 -> CHECK.
//     CHECK: obs_pos!=0 -> RUN. obs_pos==0: posture mismatch (low&var_h!=01, high&var_h!=10)
//            -> LOSE; else score+=1, obs_valid=0, then score==WIN_SCORE -> WIN, else SPAWN.
//     WIN/LOSE: W_or_L=01/10 held, obstacle frozen, key ignored.
//   Any state: presente!=PLAY_STATE -> IDLE next cycle (abort; outputs clear as in IDLE).
//   Result W_or_L is registered: appears cycle after CHECK, stays until IDLE.
//   Posture: rising edge of keypad_pressed (internal 1-flop edge detect) with key JUMP/DUCK,
//     in SPAWN/RUN/MOVE/CHECK: var_h set next cycle, hold counter=HOLD_TICKS.
//     Each tick decrements counter; on reaching 0, var_h=00. Press during hold restarts counter
//     with new posture. Held key never re-triggers.
//   Simultaneous press and tick: posture updates in the tick cycle+1 (MOVE), so CHECK sees it.
//   Press edge in same cycle as collision CHECK: not seen by that CHECK (var_h still old).
//   Score saturates at WIN_SCORE; never wraps.
//   Reset mid-round: immediate return to reset values, no W_or_L pulse.
// STRUCTURE
//   Shared header game_defs.vh: key codes, W_or_L codes, var_h encodings, PLAY_STATE
//     default, FSM state encodings (shared with fsm/display).
//   Sub-module tick_gen (parameter TICK_DIV; ports clk, rst_n, en, tick) = prescaler.
//   Rest (FSM, LFSR, posture, score) inline.
// TESTING  (sim with TICK_DIV=4, HOLD_TICKS=2, WIN_SCORE=3)
//   1 rst_n low mid-count -> all outputs 0 asynchronously; release, presente=0 -> stays IDLE.
//   2 presente=2, no keys -> first obstacle 8'hA5 glyph tipo_obs=4'h5 (high) reaches obs_pos=0
//     after 3 ticks -> W_or_L=10 cycle after CHECK; held until presente=0, then 00.
//   3 press DUCK/JUMP matching each spawned tipo_obs[0] one tick before arrival
//     -> score 1,2,3, then W_or_L=01.
//   4 hold key 5'd8 high for 20 ticks -> var_h=10 for exactly 2 ticks, then 00.
//     One event only, no retrigger.
//   5 press edge same cycle as tick preceding arrival -> var_h updated in MOVE, CHECK passes.
//   6 presente drops to 0 in RUN with score=2 -> IDLE next cycle.
//     score=0, obs_valid=0, W_or_L stays 00.

Source files
------------

// File: rtl/game_sched_pkg.sv
// ============================================================================
// Package : game_sched_pkg
// Brief   : Shared encodings for the HEROE round scheduler (key codes, result
//           codes, posture codes, scheduler states) plus small helpers.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_sched_pkg;

  // Keypad codes that move the hero; every other code is ignored
  localparam logic [4:0] KEY_JUMP = 5'd2;
  localparam logic [4:0] KEY_DUCK = 5'd8;

  // Round result reported to the top-level fsm
  localparam logic [1:0] WL_NONE = 2'b00;
  localparam logic [1:0] WL_WIN  = 2'b01;
  localparam logic [1:0] WL_LOSE = 2'b10;

  // Hero posture as shown by the display
  localparam logic [1:0] VH_STAND = 2'b00;
  localparam logic [1:0] VH_JUMP  = 2'b01;
  localparam logic [1:0] VH_DUCK  = 2'b10;

  // fsm state value that means "round in progress"
  localparam logic [2:0] PLAY_STATE_DEFAULT = 3'd2;

  // Obstacle generator seed
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_RUN   = 3'd2,
    ST_MOVE  = 3'd3,
    ST_CHECK = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } state_e;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting towards the MSB
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Posture requested by a key code; STAND means "not a posture key"
  function automatic logic [1:0] key_posture(input logic [4:0] k);
    logic [1:0] p;
    p = VH_STAND;
    if (k == KEY_JUMP) p = VH_JUMP;
    else if (k == KEY_DUCK) p = VH_DUCK;
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_sched_tick_gen.sv
// ============================================================================
// Module : tick_gen
// Brief  : Game-tick prescaler. Counts 0..TICK_DIV-1 while enabled and flags
//          the wrap cycle; held at zero while disabled.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Tick is combinational on the last count so the consumer sees it the same cycle
  assign tick = en && (cnt_q == CNT_LAST);

  // Prescaler counter: free-runs while enabled, wraps on tick, parks at 0 when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_sched.sv
// ============================================================================
// Module : game_sched
// Brief  : HEROE round scheduler. Paces the game tick, spawns and walks the
//          obstacle towards the hero digit, tracks hero posture from keypad
//          presses and reports win/lose to the top-level fsm.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_sched
  import game_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned HOLD_TICKS = 2,
  parameter int unsigned WIN_SCORE  = 16,
  parameter logic [2:0]  PLAY_STATE = PLAY_STATE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] presente,
  input  logic [4:0] key,
  input  logic       keypad_pressed,
  output logic [1:0] W_or_L,
  output logic [1:0] var_h,
  output logic [3:0] tipo_obs,
  output logic [1:0] obs_pos,
  output logic       obs_valid,
  output logic [4:0] score
);

  localparam int unsigned      HOLD_W     = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [4:0]       WIN_TARGET = 5'(WIN_SCORE);

  state_e            state_q;
  logic [7:0]        lfsr_q;
  logic              kp_q;
  logic [HOLD_W-1:0] hold_q;
  logic [1:0]        wl_q;
  logic [1:0]        var_h_q;
  logic [3:0]        tipo_q;
  logic [1:0]        pos_q;
  logic              valid_q;
  logic [4:0]        score_q;
  logic [4:0]        score_d;

  logic       tick;
  logic       tick_en;
  logic       round_ok;
  logic       in_round;
  logic       press_edge;
  logic [1:0] press_posture;
  logic       mismatch;

  assign round_ok      = (presente == PLAY_STATE);
  assign tick_en       = (state_q != ST_IDLE);
  assign in_round      = (state_q == ST_SPAWN) || (state_q == ST_RUN) ||
                         (state_q == ST_MOVE)  || (state_q == ST_CHECK);
  assign press_edge    = keypad_pressed && !kp_q;
  assign press_posture = key_posture(key);
  // Low obstacle needs a jump, high obstacle needs a duck
  assign mismatch      = tipo_q[0] ? (var_h_q != VH_DUCK) : (var_h_q != VH_JUMP);
  // Score saturates at the target so it can never wrap
  assign score_d       = (score_q < WIN_TARGET) ? (score_q + 5'd1) : score_q;

  assign W_or_L    = wl_q;
  assign var_h     = var_h_q;
  assign tipo_obs  = tipo_q;
  assign obs_pos   = pos_q;
  assign obs_valid = valid_q;
  assign score     = score_q;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .tick  (tick)
  );

  // One-flop history of the keypad level so a held key fires only once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_q <= 1'b0;
    end else begin
      kp_q <= keypad_pressed;
    end
  end

  // Hero posture: a fresh press loads the posture and the hold count, ticks run it down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      var_h_q <= VH_STAND;
      hold_q  <= '0;
    end else if (!round_ok || state_q == ST_IDLE) begin
      var_h_q <= VH_STAND;
      hold_q  <= '0;
    end else if (in_round) begin
      if (press_edge && press_posture != VH_STAND) begin
        var_h_q <= press_posture;
        hold_q  <= HOLD_LOAD;
      end else if (tick && hold_q != '0) begin
        hold_q <= hold_q - HOLD_ONE;
        if (hold_q == HOLD_ONE) begin
          var_h_q <= VH_STAND;
        end
      end
    end
  end

  // Round sequencer: spawn, advance on tick, judge at the hero digit, latch the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      wl_q    <= WL_NONE;
      tipo_q  <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      score_q <= '0;
    end else if (!round_ok) begin
      // Abort from anywhere; the LFSR keeps its place so rounds differ
      state_q <= ST_IDLE;
      wl_q    <= WL_NONE;
      tipo_q  <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      score_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wl_q    <= WL_NONE;
          tipo_q  <= '0;
          pos_q   <= '0;
          valid_q <= 1'b0;
          score_q <= '0;
          state_q <= ST_SPAWN;
        end
        ST_SPAWN: begin
          pos_q   <= 2'd3;
          valid_q <= 1'b1;
          tipo_q  <= lfsr_q[3:0];
          lfsr_q  <= lfsr_next(lfsr_q);
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            state_q <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          pos_q   <= pos_q - 2'd1;
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (pos_q != 2'd0) begin
            state_q <= ST_RUN;
          end else if (mismatch) begin
            wl_q    <= WL_LOSE;
            state_q <= ST_LOSE;
          end else begin
            score_q <= score_d;
            valid_q <= 1'b0;
            if (score_d == WIN_TARGET) begin
              wl_q    <= WL_WIN;
              state_q <= ST_WIN;
            end else begin
              state_q <= ST_SPAWN;
            end
          end
        end
        ST_WIN, ST_LOSE: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_sched.sv
// ============================================================================
// Module : tb_game_sched
// Brief  : Self-checking bench for game_sched with a cycle-level reference
//          model and randomized keypad/fsm stimulus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_sched;

  localparam int         TD   = 4;
  localparam int         HOLD = 2;
  localparam int         WIN  = 3;
  localparam logic [2:0] PLAY = 3'd2;

  localparam int PH_IDLE  = 0;
  localparam int PH_SPAWN = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_MOVE  = 3;
  localparam int PH_CHECK = 4;
  localparam int PH_OVER  = 5;

  logic       clk;
  logic       rst_n;
  logic [2:0] presente;
  logic [4:0] key;
  logic       keypad_pressed;
  logic [1:0] W_or_L;
  logic [1:0] var_h;
  logic [3:0] tipo_obs;
  logic [1:0] obs_pos;
  logic       obs_valid;
  logic [4:0] score;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int         m_ph, m_cyc, m_ticks, m_expire;
  int         m_wl, m_score, m_vh, m_pos;
  bit         m_valid, m_kp_prev;
  logic [3:0] m_tipo;
  logic [7:0] m_lfsr;

  game_sched #(
    .TICK_DIV   (TD),
    .HOLD_TICKS (HOLD),
    .WIN_SCORE  (WIN),
    .PLAY_STATE (PLAY)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .presente       (presente),
    .key            (key),
    .keypad_pressed (keypad_pressed),
    .W_or_L         (W_or_L),
    .var_h          (var_h),
    .tipo_obs       (tipo_obs),
    .obs_pos        (obs_pos),
    .obs_valid      (obs_valid),
    .score          (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Feedback is the parity of the tapped bits 8,6,5,4
  function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic clear_round();
    m_wl = 0; m_score = 0; m_valid = 0; m_vh = 0; m_pos = 0; m_tipo = '0;
  endtask

  task automatic model_reset();
    clear_round();
    m_ph = PH_IDLE; m_cyc = 0; m_lfsr = 8'hA5; m_kp_prev = 0;
    m_ticks = 0; m_expire = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled
  task automatic step_model();
    bit tk, edg, act, press;
    int old_vh, need;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk        = (m_ph != PH_IDLE) && ((m_cyc % TD) == TD - 1);
    edg       = keypad_pressed && !m_kp_prev;
    m_kp_prev = keypad_pressed;
    act       = (m_ph >= PH_SPAWN) && (m_ph <= PH_CHECK);
    old_vh    = m_vh;
    m_cyc     = (m_ph == PH_IDLE) ? 0 : m_cyc + 1;
    if (presente != PLAY) begin
      clear_round();
      m_ph = PH_IDLE;
      return;
    end
    if (act) begin
      if (tk) m_ticks++;
      press = edg && (key == 5'd2 || key == 5'd8);
      if (press) begin
        m_vh     = (key == 5'd2) ? 1 : 2;
        m_expire = m_ticks + HOLD;
      end else if (tk && m_vh != 0 && m_ticks == m_expire) begin
        m_vh = 0;
      end
    end
    case (m_ph)
      PH_IDLE: begin clear_round(); m_ph = PH_SPAWN; end
      PH_SPAWN: begin
        m_pos = 3; m_valid = 1; m_tipo = m_lfsr[3:0];
        m_lfsr = lfsr_adv(m_lfsr); m_ph = PH_RUN;
      end
      PH_RUN:  if (tk) m_ph = PH_MOVE;
      PH_MOVE: begin m_pos = m_pos - 1; m_ph = PH_CHECK; end
      PH_CHECK: begin
        if (m_pos != 0) m_ph = PH_RUN;
        else begin
          need = m_tipo[0] ? 2 : 1;
          if (old_vh != need) begin
            m_wl = 2; m_ph = PH_OVER;
          end else begin
            if (m_score < WIN) m_score++;
            m_valid = 0;
            if (m_score == WIN) begin m_wl = 1; m_ph = PH_OVER; end
            else m_ph = PH_SPAWN;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("W_or_L", W_or_L, m_wl);
    check("score", score, m_score);
    check("obs_valid", obs_valid, m_valid);
    if (m_ph != PH_OVER) check("var_h", var_h, m_vh);
    if (m_valid) begin
      check("obs_pos", obs_pos, m_pos);
      check("tipo_obs", tipo_obs, m_tipo);
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    step_model();
    @(negedge clk);
    compare_all();
  endtask

  // Keypad behaviour: 0 random noise, 1 correct key one tick early, 2 correct key on the last tick
  task automatic drive(input int mode);
    int r;
    case (mode)
      0: begin
        if ($urandom_range(0, 3) == 0) keypad_pressed = ~keypad_pressed;
        if ($urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 2);
          key = (r == 0) ? 5'd2 : (r == 1) ? 5'd8 : 5'($urandom_range(0, 31));
        end
      end
      1: begin
        keypad_pressed = (m_ph == PH_RUN) && (m_pos == 1);
        key = m_tipo[0] ? 5'd8 : 5'd2;
      end
      default: begin
        keypad_pressed = (m_ph == PH_RUN) && (m_pos == 1) && ((m_cyc % TD) == TD - 1);
        key = m_tipo[0] ? 5'd8 : 5'd2;
      end
    endcase
  endtask

  task automatic play_until_over(input int mode, input string tag);
    int n;
    n = 0;
    while (m_ph != PH_OVER && n < 400) begin
      drive(mode);
      run_cycle();
      n++;
    end
    if (m_ph != PH_OVER) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic go_idle();
    presente = 3'd0; keypad_pressed = 1'b0; key = 5'd0;
    run_cycle();
    run_cycle();
  endtask

  initial begin
    int n, mode, over_cnt;
    rst_n = 1'b0; presente = 3'd0; key = 5'd0; keypad_pressed = 1'b0;
    model_reset();
    repeat (3) run_cycle();
    rst_n = 1'b1;
    repeat (3) run_cycle();

    // 1: asynchronous reset in the middle of a tick count
    presente = PLAY;
    repeat (6) run_cycle();
    @(posedge clk);
    step_model();
    #2 rst_n = 1'b0;
    #1;
    check("rst_W_or_L", W_or_L, 0);
    check("rst_var_h", var_h, 0);
    check("rst_tipo", tipo_obs, 0);
    check("rst_pos", obs_pos, 0);
    check("rst_valid", obs_valid, 0);
    check("rst_score", score, 0);
    model_reset();
    presente = 3'd0;
    run_cycle();
    rst_n = 1'b1;
    repeat (3) run_cycle();
    check("idle_stays", obs_valid, 0);

    // 2: no keys, first obstacle from seed A5 is high -> lose
    presente = PLAY;
    n = 0;
    while (!m_valid && n < 10) begin run_cycle(); n++; end
    check("t2_first_tipo", tipo_obs, 5);
    play_until_over(0, "t2");
    check("t2_lose", W_or_L, 2);
    repeat (5) run_cycle();
    check("t2_lose_held", W_or_L, 2);
    presente = 3'd0;
    run_cycle();
    check("t2_cleared", W_or_L, 0);
    go_idle();

    // 3: correct key one tick before arrival -> win
    presente = PLAY;
    play_until_over(1, "t3");
    check("t3_win", W_or_L, 1);
    check("t3_score", score, WIN);
    go_idle();

    // 4: DUCK held for many ticks fires once
    presente = PLAY;
    run_cycle();
    key = 5'd8; keypad_pressed = 1'b1;
    run_cycle();
    run_cycle();
    check("t4_duck", var_h, 2);
    repeat (20 * TD) run_cycle();
    go_idle();

    // 5: press lands in the same cycle as the arrival tick -> still clears
    presente = PLAY;
    play_until_over(2, "t5");
    check("t5_win", W_or_L, 1);
    go_idle();

    // 6: abort in RUN with score 2
    presente = PLAY;
    n = 0;
    while (!(m_score == 2 && m_ph == PH_RUN) && n < 400) begin
      drive(1); run_cycle(); n++;
    end
    check("t6_reached", score, 2);
    presente = 3'd0;
    run_cycle();
    check("t6_score", score, 0);
    check("t6_valid", obs_valid, 0);
    check("t6_wl", W_or_L, 0);
    go_idle();

    // Randomized play with random aborts and keying styles
    mode = 0; over_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if (m_ph == PH_OVER) over_cnt++; else over_cnt = 0;
      if (over_cnt > 3 || $urandom_range(0, 199) == 0) begin
        presente = 3'($urandom_range(0, 7));
        if (presente == PLAY) presente = 3'd5;
        mode = $urandom_range(0, 2);
      end else begin
        presente = PLAY;
      end
      drive(mode);
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
